// File: rtl/alu_bcd_display_if.sv
// alu_bcd_display_if: board-side switches, buttons and display lines of the ALU/BCD block
interface alu_bcd_display_if #(parameter int Bits = 8, parameter int Digits = 3);
   logic                opsel;
   logic [Bits-1:0]     vA;
   logic [Bits-1:0]     vB;
   logic [6:0]          minus;
   logic [7*Digits-1:0] digits;
   logic [3:0]          ALUflags;
   logic [3:0]          operation;
   logic                busy;
   modport master (output opsel, vA, vB, input minus, digits, ALUflags, operation, busy);
   modport slave  (input opsel, vA, vB, output minus, digits, ALUflags, operation, busy);
endinterface

// File: rtl/alu_bcd_display.sv
// alu_bcd_display: registered signed ALU with button-stepped op and double-dabble 7-segment output
module alu_bcd_display #(
   parameter int Bits   = 8,
   parameter int Digits = 3
) (
   input logic             clk,
   input logic             rst,
   alu_bcd_display_if.slave bus
);
   localparam int W  = 4*Digits + Bits;
   localparam int CW = $clog2(Bits);

   function automatic longint pow10(input int n);
      longint p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   if (Bits < 4 || Bits > 16 || pow10(Digits) <= (longint'(1) << (Bits-1))) begin : g_bad_params
      $error("alu_bcd_display: Bits must be 4..16 and 10^Digits > 2^(Bits-1)");
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: seg7 = 7'b1000000;
         4'd1: seg7 = 7'b1111001;
         4'd2: seg7 = 7'b0100100;
         4'd3: seg7 = 7'b0110000;
         4'd4: seg7 = 7'b0011001;
         4'd5: seg7 = 7'b0010010;
         4'd6: seg7 = 7'b0000010;
         4'd7: seg7 = 7'b1111000;
         4'd8: seg7 = 7'b0000000;
         4'd9: seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          sync_q;
   logic [3:0]          op_q, fl_q, fl_d;
   logic [Bits-1:0]     r_q, r_d, last_q, last_d, opb, sum, mag;
   logic                carry, sub, arith, sign_q, sign_d, dsign_q, dsign_d, lit;
   logic [W-1:0]        sh_q, sh_d, adj;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [4*Digits-1:0] dig_q, dig_d;
   logic [7*Digits-1:0] seg;

   assign sub   = op_q[1];
   assign arith = op_q[0] | op_q[1];
   assign opb   = sub ? ~bus.vB : bus.vB;
   assign {carry, sum} = {1'b0, bus.vA} + {1'b0, opb} + (Bits+1)'(sub);
   assign r_d   = op_q[2] ? (bus.vA & bus.vB) : op_q[3] ? (bus.vA | bus.vB) : sum;
   assign fl_d  = {r_d[Bits-1], r_d == '0, arith & carry,
                   arith & (bus.vA[Bits-1] == opb[Bits-1]) & (sum[Bits-1] != bus.vA[Bits-1])};
   assign mag   = r_q[Bits-1] ? -r_q : r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         op_q    <= 4'b0001;
         r_q     <= '0;
         fl_q    <= 4'b0100;
         state_q <= IDLE;
         last_q  <= '0;
         sign_q  <= 1'b0;
         sh_q    <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
         dsign_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], bus.opsel};
         op_q    <= (sync_q[1] & ~sync_q[2]) ? {op_q[2:0], op_q[3]} : op_q;
         r_q     <= r_d;
         fl_q    <= fl_d;
         state_q <= state_d;
         last_q  <= last_d;
         sign_q  <= sign_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         dsign_q <= dsign_d;
      end
   end

   always_comb begin
      adj = sh_q;
      for (int i = 0; i < Digits; i++)
         if (sh_q[Bits+4*i +: 4] >= 4'd5) adj[Bits+4*i +: 4] = sh_q[Bits+4*i +: 4] + 4'd3;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sign_d  = sign_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      dsign_d = dsign_q;
      case (state_q)
         IDLE: if (r_q != last_q) begin
            state_d = SHIFT;
            last_d  = r_q;
            sign_d  = r_q[Bits-1];
            sh_d    = {{(4*Digits){1'b0}}, mag};
            cnt_d   = '0;
         end
         SHIFT: begin
            sh_d    = {adj[W-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(Bits-1)) ? DONE : SHIFT;
         end
         default: begin
            dig_d   = sh_q[W-1 -: 4*Digits];
            dsign_d = sign_q;
            state_d = IDLE;
         end
      endcase
   end

   // Leading-zero blanking: a digit is lit once any digit at or above it is nonzero.
   always_comb begin
      lit = 1'b0;
      seg = '1;
      for (int i = Digits-1; i >= 0; i--) begin
         lit = lit | (dig_q[4*i +: 4] != 4'd0) | (i == 0);
         seg[7*i +: 7] = lit ? seg7(dig_q[4*i +: 4]) : 7'b1111111;
      end
   end

   assign bus.digits    = seg;
   assign bus.minus     = (dsign_q && dig_q != '0) ? 7'b0111111 : 7'b1111111;
   assign bus.busy      = state_q != IDLE;
   assign bus.operation = op_q;
   assign bus.ALUflags  = fl_q;
endmodule

// File: tb/tb_alu_bcd_display.sv
// tb_alu_bcd_display: scoreboard bench for the ALU/BCD display block at Bits=8, Digits=3
module tb_alu_bcd_display;
   localparam int Bits = 8, Digits = 3;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                       7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   typedef struct {
      logic [20:0] dig;
      logic [6:0]  mn;
      logic [3:0]  fl;
      logic [3:0]  op;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] op_m = 4'b0001;
   int         tests = 0;
   int         fails = 0;
   exp_t       sb[$];

   alu_bcd_display_if #(.Bits(Bits), .Digits(Digits)) bus ();
   alu_bcd_display #(.Bits(Bits), .Digits(Digits)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      exp_t e;
      int sa, sb_, ua, ub, s, r, mag, d0, d1, d2;
      logic [7:0] rr;
      logic c, v;
      sa = int'($signed(a)); sb_ = int'($signed(b));
      ua = int'(a); ub = int'(b);
      s  = op[1] ? sa - sb_ : sa + sb_;
      c  = op[1] ? (ua >= ub) : (ua + ub > 255);
      v  = (s > 127) || (s < -128);
      rr = s[7:0];
      if (op[2]) begin rr = a & b; c = 1'b0; v = 1'b0; end
      if (op[3]) begin rr = a | b; c = 1'b0; v = 1'b0; end
      r   = int'($signed(rr));
      mag = (r < 0) ? -r : r;
      d0 = mag % 10; d1 = (mag / 10) % 10; d2 = mag / 100;
      e.fl  = {rr[7], rr == 8'd0, c, v};
      e.dig = {(d2 != 0) ? SEG[d2] : BLANK, (d1 != 0 || d2 != 0) ? SEG[d1] : BLANK, SEG[d0]};
      e.mn  = (r < 0) ? 7'b0111111 : BLANK;
      e.op  = op;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pop_cmp(input string tag, input bit with_fl);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_digits"}, 32'(bus.digits), 32'(e.dig));
      chk({tag, "_minus"}, 32'(bus.minus), 32'(e.mn));
      if (with_fl) begin
         chk({tag, "_flags"}, 32'(bus.ALUflags), 32'(e.fl));
         chk({tag, "_op"}, 32'(bus.operation), 32'(e.op));
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_op"}, 32'(bus.operation), 32'b0001);
      chk({tag, "_flags"}, 32'(bus.ALUflags), 32'b0100);
      chk({tag, "_digits"}, 32'(bus.digits), 32'({BLANK, BLANK, 7'b1000000}));
      chk({tag, "_minus"}, 32'(bus.minus), 32'(BLANK));
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic convert(input string tag, input logic [7:0] a, input logic [7:0] b);
      int n, hi;
      bus.vA = a; bus.vB = b;
      sb.push_back(model(a, b, op_m));
      n = 0; hi = 0;
      while (n < 40) begin
         @(negedge clk); n++;
         if (bus.busy) hi++;
         else if (hi > 0) break;
      end
      chk({tag, "_latency"}, 32'(n - 1), 32'd10);
      chk({tag, "_busy_cycles"}, 32'(hi), 32'd9);
      pop_cmp(tag, 1'b1);
   endtask

   task automatic settle(input string tag);
      int n, idle;
      n = 0; idle = 0;
      while (idle < 3 && n < 100) begin
         @(negedge clk); n++;
         idle = bus.busy ? 0 : idle + 1;
      end
      chk({tag, "_settled"}, 32'(idle >= 3), 32'd1);
      pop_cmp(tag, 1'b1);
   endtask

   task automatic press(input string tag, input int hold);
      op_m = {op_m[2:0], op_m[3]};
      sb.push_back(model(bus.vA, bus.vB, op_m));
      bus.opsel = 1'b1;
      repeat (hold) @(negedge clk);
      bus.opsel = 1'b0;
      chk({tag, "_op_now"}, 32'(bus.operation), 32'(op_m));
      settle(tag);
   endtask

   task automatic mid_change();
      int n, gap;
      bus.vA = 8'd1; bus.vB = 8'd1;
      sb.push_back(model(8'd1, 8'd1, op_m));
      n = 0;
      while (!bus.busy && n < 20) begin @(negedge clk); n++; end
      repeat (4) @(negedge clk);
      bus.vB = 8'd2;
      sb.push_back(model(8'd1, 8'd2, op_m));
      n = 0;
      while (bus.busy && n < 20) begin @(negedge clk); n++; end
      pop_cmp("mid_first", 1'b0);
      gap = 0;
      while (!bus.busy && gap < 20) begin @(negedge clk); gap++; end
      chk("mid_gap", 32'(gap), 32'd1);
      n = 0;
      while (bus.busy && n < 20) begin @(negedge clk); n++; end
      pop_cmp("mid_second", 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.opsel = 1'b0; bus.vA = '0; bus.vB = '0;
      repeat (3) @(negedge clk);
      reset_checks("rst_init");
      rst = 1'b0;
      @(negedge clk);
      bus.vA = 8'd100; bus.vB = 8'd27;
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2 rst = 1'b1;
      #1 reset_checks("rst_mid");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      convert("add_127", 8'd100, 8'd27);
      press("to_sub", 5);
      convert("sub_m4", 8'd5, 8'd9);
      press("to_and", 5);
      convert("and_48", 8'hF0, 8'h3C);
      press("to_or", 5);
      press("to_add", 5);
      press("held", 20);
      press("cyc_and", 5);
      press("cyc_or", 5);
      press("cyc_add", 5);
      convert("ovf_m128", 8'd127, 8'd1);
      convert("ovf_zero", 8'h80, 8'h80);
      mid_change();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_bcd_display.md
# alu_bcd_display

- Parametrised successor to the 5-bit ALU/7-segment top level.
- Registers a Bits-wide signed ALU result and its flags.
- Steps the operation with a synchronised, edge-detected select button.
- Converts the signed result to sign + Digits BCD digits with a sequential double-dabble FSM and drives active-low 7-segment outputs with leading-zero blanking.
- Sits between the board switches/buttons and the seven-segment bank.

## Interface
Parameters:
- Bits, 8, operand/result width, two's complement; legal range 4..16.
- Digits, 3, number of decimal digit outputs; must satisfy 10^Digits > 2^(Bits-1) (simulation assertion at elaboration).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- opsel  in  1  raw operation-select button, active-high, asynchronous to clk.
- vA  in  Bits  operand A, signed.
- vB  in  Bits  operand B, signed.
- minus  out  7  sign segment, active-low gfedcba.
- digits  out  7*Digits  digit segments; digits[6:0] = units, next 7 bits = tens, and so on.
- ALUflags  out  4  {N,Z,C,V}, registered.
- operation  out  4  one-hot operation: ADD=0001, SUB=0010, AND=0100, OR=1000.
- busy  out  1  high while a conversion is in progress.

## Operation
- Op select:
  - opsel passes through a 2-flop synchroniser plus one history flop.
  - A rising edge (sync2 & ~sync3) advances the op: ADD->SUB->AND->OR->ADD.
  - Holding opsel high advances the op only once.
- ALU, registered every cycle from the current vA, vB and op:
  - ADD: R = A+B mod 2^Bits; C = carry out; V = signed overflow.
  - SUB: R = A+~B+1 mod 2^Bits; C = carry out (1 = no borrow, A>=B unsigned); V = signed overflow.
  - AND/OR: bitwise; C=0, V=0.
  - N = R[Bits-1]; Z = (R==0).
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: if registered R != last_R, capture sign = N and magnitude = N ? -R : R. Magnitude is treated as Bits-bit unsigned, so -2^(Bits-1) gives 2^(Bits-1). Load the shift register {4*Digits zeros, magnitude}, last_R <= R, go to SHIFT with counter = 0.
  - SHIFT: add-3 to each BCD nibble >= 5, then shift left by 1. After Bits shifts go to DONE.
  - DONE: copy BCD nibbles and sign to the display registers, return to IDLE.
  - busy = (state != IDLE).
- Display:
  - Segment codes for 0..9 are standard active-low gfedcba; 0 = 1000000, blank = 1111111.
  - Digits above the most significant nonzero digit are blank. Units always lit.
  - minus = 0111111 (g only) when the displayed sign is negative and magnitude != 0; otherwise blank.
- Display registers hold the previous value for the whole conversion (no flicker).

## Timing
- Reset, asynchronous and immediate:
  - op = ADD, operation = 0001.
  - ALU result = 0, ALUflags = 0100.
  - last_R = 0, state = IDLE, busy = 0.
  - digits = units "0", upper digits blank; minus blank.
  - Synchroniser flops = 0.
  - Because last_R equals R after reset, no conversion starts.
- Operand change before edge E:
  - Registered R/flags update at E.
  - busy rises at E+1 (load).
  - Shifts occur on E+2..E+1+Bits.
  - Display updates and busy falls at E+2+Bits.
  - Total latency is Bits+2 cycles from E; 10 cycles for Bits=8.
- opsel rising edge sampled at edge S: operation changes at S+2, ALU registers the new op at S+3.
- Result change while busy:
  - The conversion in progress finishes with the captured value.
  - On DONE the FSM returns to IDLE, sees R != last_R the following cycle, and restarts.
  - busy drops for exactly one cycle (the IDLE cycle) between the two conversions.
- Result that changes and returns to last_R before IDLE samples it: no conversion, display unchanged.
- rst asserted mid-SHIFT: conversion aborted, all outputs to reset values; the partial result is never shown.

## Test plan
- Reset: hold rst during SHIFT with vA=100, vB=27 -> immediately operation=0001, ALUflags=0100, units "0" (1000000), upper digits/minus blank, busy=0; after release a full conversion to 127 completes in 10 cycles.
- ADD, Bits=8: vA=100, vB=27 -> after 10 cycles digits show 1,2,7; minus blank; flags 0000; busy high for exactly 9 cycles.
- SUB: one opsel press, vA=5, vB=9 -> operation=0010; display "-4" (minus 0111111, units 4, tens/hundreds blank); flags N=1, Z=0, C=0, V=0.
- Overflow: ADD, vA=127, vB=1 -> R=0x80, flags N=1, V=1, C=0; display -128. Also vA=vB=-128 -> R=0, flags Z=1, C=1, V=1; display "0", minus blank.
- Op cycling: 4 opsel pulses (each held 5 cycles) -> operation 0010, 0100, 1000, 0001. With AND, vA=0xF0, vB=0x3C -> display 48. With OR -> 0xFC = -4. A held opsel level advances the op only once.
- Mid-conversion change: ADD, vA=1, vB=1, then change vB to 2 at cycle 4 of SHIFT -> display shows 2 first, then 3 after the restart; busy low for one cycle between the two conversions.
